// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared definitions for the pipeline controller: control-FSM
//               state encoding, the NOP instruction word loaded into the
//               FETCH/DECODE latch on a flush, event-counter width and the
//               register-match helper used by the load-use hazard check.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Width and ceiling of the stall / flush event counters
  localparam int                 c_cnt_w   = 16;
  localparam logic [c_cnt_w-1:0] c_cnt_max = {c_cnt_w{1'b1}};
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  // Instruction word the FETCH/DECODE latch loads when fd_flush is high
  localparam logic [15:0] c_nop_instr = 16'h1000;

  // Register-file address width of the source / destination fields
  localparam int c_reg_w = 3;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,  // normal issue
    ST_STALL  = 2'd1,  // one-cycle load-use recovery
    ST_DRAIN  = 2'd2,  // halt in flight, waiting for it to reach WRITEBACK
    ST_HALTED = 2'd3   // pipeline stopped, waiting for resume
  } state_t;

  // True when a source field is actually read and names the given register
  function automatic logic src_match(
    input logic               use_src,
    input logic [c_reg_w-1:0] src,
    input logic [c_reg_w-1:0] dst
  );
    return use_src && (src == dst);
  endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_sat_cnt16.sv
`default_nettype none
// ============================================================================
// Module      : sat_cnt16
// Description : 16-bit saturating event counter. Adds one per cycle while
//               inc is high and sticks at all-ones instead of wrapping.
// Ports       : clk   - clock, rising edge
//               rst   - asynchronous active-high reset, clears the count
//               inc   - count this cycle
//               count - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_cnt16
  import pipe_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [c_cnt_w-1:0] count
);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != c_cnt_max)) begin
      r_count <= r_count + c_cnt_one;
    end
  end

  assign count = r_count;

endmodule : sat_cnt16
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard / flush / halt controller for a 5-stage core.
//               Detects load-use hazards between DECODE and EXECUTE, applies
//               branch flushes resolved in EXECUTE, drains the pipeline on a
//               halt instruction and restarts it on a resume pulse. Pipeline
//               enables are combinational from the current state so they act
//               in the same cycle as the triggering event.
// Ports       : clk, rst                 - clock, async active-high reset
//               dec_rqrd/rs, dec_use_*   - DECODE source fields and usage
//               dec_halt                 - DECODE holds a halt
//               ex_mem_read, ex_write_en - EXECUTE is a load / writes a reg
//               ex_write_reg             - EXECUTE destination register
//               ex_flush                 - taken branch/jump in EXECUTE
//               wb_halt                  - halt reached WRITEBACK
//               resume                   - restart pulse from HALTED
//               pc_en, fd_en             - PC / FETCH-DECODE enables
//               fd_flush                 - load NOP into FETCH/DECODE
//               dx_bubble                - clear DECODE/EXECUTE latch
//               halted                   - pipeline fully halted
//               stall_cnt, flush_cnt     - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [c_reg_w-1:0] dec_rqrd,
  input  logic [c_reg_w-1:0] dec_rs,
  input  logic               dec_use_rqrd,
  input  logic               dec_use_rs,
  input  logic               dec_halt,
  input  logic               ex_mem_read,
  input  logic               ex_write_en,
  input  logic [c_reg_w-1:0] ex_write_reg,
  input  logic               ex_flush,
  input  logic               wb_halt,
  input  logic               resume,
  output logic               pc_en,
  output logic               fd_en,
  output logic               fd_flush,
  output logic               dx_bubble,
  output logic               halted,
  output logic [c_cnt_w-1:0] stall_cnt,
  output logic [c_cnt_w-1:0] flush_cnt
);

  state_t r_state;
  state_t w_next_state;
  logic   r_halted;

  logic w_hazard;
  logic w_pc_en;
  logic w_fd_en;
  logic w_fd_flush;
  logic w_dx_bubble;
  logic w_stall_inc;
  logic w_flush_inc;

  // Load-use hazard: EXECUTE is loading a register that DECODE reads
  assign w_hazard = ex_mem_read && ex_write_en &&
                    (src_match(dec_use_rqrd, dec_rqrd, ex_write_reg) ||
                     src_match(dec_use_rs,   dec_rs,   ex_write_reg));

  // --------------------------------------------------------------------------
  // Next-state and same-cycle control decode.
  // A flush always wins (except in HALTED, where nothing is in flight): the
  // instructions behind the branch are wrong-path, so any stall or halt they
  // would trigger is discarded along with them. The hazard is only looked at
  // in RUN; in STALL the load has already moved on, and in DRAIN the DECODE
  // slot only ever holds the NOP we are feeding in.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_pc_en      = 1'b0;
    w_fd_en      = 1'b0;
    w_fd_flush   = 1'b0;
    w_dx_bubble  = 1'b0;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (ex_flush) begin
          w_pc_en      = 1'b1;
          w_fd_en      = 1'b1;
          w_fd_flush   = 1'b1;
          w_dx_bubble  = 1'b1;
          w_flush_inc  = 1'b1;
          w_next_state = ST_RUN;
        end else if (w_hazard) begin
          // Hold PC and FETCH/DECODE, push a bubble into EXECUTE
          w_dx_bubble  = 1'b1;
          w_stall_inc  = 1'b1;
          w_next_state = ST_STALL;
        end else if (dec_halt) begin
          // Let the halt proceed, stop fetching behind it
          w_fd_en      = 1'b1;
          w_fd_flush   = 1'b1;
          w_next_state = ST_DRAIN;
        end else begin
          w_pc_en      = 1'b1;
          w_fd_en      = 1'b1;
          w_next_state = ST_RUN;
        end
      end

      ST_STALL: begin
        if (ex_flush) begin
          w_pc_en      = 1'b1;
          w_fd_en      = 1'b1;
          w_fd_flush   = 1'b1;
          w_dx_bubble  = 1'b1;
          w_flush_inc  = 1'b1;
          w_next_state = ST_RUN;
        end else begin
          // Stalled instruction now advances; a halt sitting in DECODE
          // after the stall goes straight into the drain sequence
          w_pc_en      = 1'b1;
          w_fd_en      = 1'b1;
          w_next_state = dec_halt ? ST_DRAIN : ST_RUN;
        end
      end

      ST_DRAIN: begin
        if (ex_flush) begin
          // The halt was on the wrong path; abandon the drain
          w_pc_en      = 1'b1;
          w_fd_en      = 1'b1;
          w_fd_flush   = 1'b1;
          w_dx_bubble  = 1'b1;
          w_flush_inc  = 1'b1;
          w_next_state = ST_RUN;
        end else begin
          w_fd_en      = 1'b1;
          w_fd_flush   = 1'b1;
          w_dx_bubble  = 1'b1;
          w_next_state = wb_halt ? ST_HALTED : ST_DRAIN;
        end
      end

      ST_HALTED: begin
        w_dx_bubble  = 1'b1;
        w_next_state = resume ? ST_RUN : ST_HALTED;
      end

      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register with registered halted flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_halted <= (w_next_state == ST_HALTED);
    end
  end

  // While reset is held the pipeline is frozen and fed NOPs/bubbles,
  // independent of the clock.
  assign pc_en     = w_pc_en     && !rst;
  assign fd_en     = w_fd_en     && !rst;
  assign fd_flush  = w_fd_flush  ||  rst;
  assign dx_bubble = w_dx_bubble ||  rst;
  assign halted    = r_halted;

  // --------------------------------------------------------------------------
  // Event counters
  // --------------------------------------------------------------------------
  sat_cnt16 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_cnt16 u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );

endmodule : pipe_ctrl
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single pipeline clock; all state changes on the rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port dec_rqrd, dec_rs  input  3 each  source register fields of the instruction in DECODE.
REQ-004 SHALL have port dec_use_rqrd, dec_use_rs  input  1 each  DECODE instruction reads that source.
REQ-005 SHALL have port dec_halt  input  1  DECODE holds a halt instruction.
REQ-006 SHALL have port ex_mem_read, ex_write_en  input  1 each  EXECUTE instruction is a load / writes a register.
REQ-007 SHALL have port ex_write_reg  input  3  destination register of the EXECUTE instruction.
REQ-008 SHALL have port ex_flush  input  1  taken branch or jump resolved in EXECUTE.
REQ-009 SHALL have port wb_halt  input  1  halt has reached WRITEBACK.
REQ-010 SHALL have port resume  input  1  single-cycle pulse that restarts the pipeline from HALTED.
REQ-011 SHALL have port pc_en  output  1  fetch PC register update enable.
REQ-012 SHALL have port fd_en  output  1  FETCH/DECODE latch enable.
REQ-013 SHALL have port fd_flush  output  1  load NOP (16'h1000) into FETCH/DECODE.
REQ-014 SHALL have port dx_bubble  output  1  clear the DECODE/EXECUTE latch (insert bubble).
REQ-015 SHALL have port halted  output  1  pipeline fully halted.
REQ-016 SHALL have port stall_cnt, flush_cnt  output  16 each  saturating event counters.

Function
REQ-017 SHALL implement states RUN, STALL, DRAIN and HALTED.
REQ-018 SHALL define the hazard as ex_mem_read & ex_write_en & ((dec_use_rqrd & dec_rqrd==ex_write_reg) | (dec_use_rs & dec_rs==ex_write_reg)).
REQ-019 SHALL drive pc_en, fd_en, fd_flush and dx_bubble combinationally from state and inputs in the same cycle; there SHALL be no added latency.
REQ-020 SHALL give event priority ex_flush > hazard > dec_halt in RUN and DRAIN.
REQ-021 In RUN with ex_flush: pc_en=1, fd_en=1, fd_flush=1, dx_bubble=1, flush_cnt+1; next state RUN.
REQ-022 In RUN with hazard and no ex_flush: pc_en=0, fd_en=0, dx_bubble=1, stall_cnt+1; next state STALL.
REQ-023 SHALL remain in STALL for exactly one cycle, with hazard detection masked. In STALL: pc_en=1, fd_en=1, no bubble. Next state RUN, or DRAIN if dec_halt.
REQ-024 ex_flush in STALL SHALL be handled as in REQ-021 and return to RUN.
REQ-025 In RUN with dec_halt and no higher-priority event: pc_en=0, fd_en=1, fd_flush=1; next state DRAIN.
REQ-026 In DRAIN: pc_en=0, fd_flush=1, dx_bubble=1. Stay in DRAIN until wb_halt, then go to HALTED.
REQ-027 ex_flush in DRAIN (wrong-path halt) SHALL apply REQ-021 and return to RUN; ex_flush SHALL win over a simultaneous wb_halt.
REQ-028 In HALTED: pc_en=0, fd_en=0, dx_bubble=1, halted=1. resume SHALL go to RUN with pc_en=1 in the following cycle.
REQ-029 resume outside HALTED SHALL be ignored.
REQ-030 In RUN with no event: pc_en=1, fd_en=1; all other controls 0.
REQ-031 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-032 Counters SHALL increment at most once per cycle.

Reset
REQ-033 While rst is high: state=RUN, pc_en=0, fd_en=0, fd_flush=1, dx_bubble=1, halted=0, stall_cnt=0, flush_cnt=0.
REQ-034 After rst deasserts: RUN outputs per REQ-030 from the first clock edge.
REQ-035 rst asserted mid-STALL or mid-DRAIN SHALL abandon the operation immediately, with no pending counter update.

Structure
REQ-036 SHALL place the state encoding, the NOP constant 16'h1000 and counter width 16 in shared package pipe_ctrl_pkg.
REQ-037 SHALL instantiate sub-module sat_cnt16 twice, once for stall_cnt and once for flush_cnt.
REQ-038 Hazard compare SHALL be inline combinational logic, not a separate module.

Verification
REQ-039 Load-use: ex_mem_read=1, ex_write_en=1, ex_write_reg=3, dec_rs=3, dec_use_rs=1 -> one cycle with pc_en=0 and dx_bubble=1, then STALL, then RUN; stall_cnt=1.
REQ-040 Flush plus hazard in the same cycle -> flush action only; flush_cnt=1, stall_cnt=0.
REQ-041 dec_halt, then wb_halt three cycles later -> DRAIN for 3 cycles, then halted=1; resume -> pc_en=1 in the next cycle.
REQ-042 DRAIN with ex_flush and wb_halt together -> RUN, halted=0, flush_cnt+1.
REQ-043 Saturation: preload 16'hFFFE and apply 3 hazards -> stall_cnt holds 16'hFFFF.
REQ-044 rst pulsed during DRAIN and asynchronous to clk -> outputs take reset values immediately, state=RUN.
